fetch_unit: RTL

Instruction-fetch stage of the P6 pipelined MIPS core. Holds the fetch PC, exports PC+4 to the next-PC selection logic, fetches through a request/response handshake to instruction memory, and drives the IF/ID pipeline register. The block absorbs hazard-unit stalls and memory wait states, and flags misaligned or out-of-range fetch addresses.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/ifid_reg.sv | 27 ++
 rtl/fetch_unit.sv | 67 ++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch constants, fetch-state enum and fetch-address legality check
package cpu_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam int unsigned IM_DEPTH_DEF = 1024;
  localparam logic [31:0] NOP_INSTR = 32'h0;
  typedef enum logic [1:0] {FS_REQ, FS_WAIT, FS_HELD} fetch_state_e;
  function automatic logic addr_legal(input logic [31:0] pc, input logic [31:0] base, input int unsigned depth);
    logic [33:0] off, lim;
    off = {2'b00, pc} - {2'b00, base};
    lim = {2'b00, 32'(depth)} << 2;
    return pc[1:0] == 2'b00 && pc >= base && off < lim;
  endfunction
endpackage

// File: rtl/ifid_reg.sv
// ifid_reg: IF/ID register {instr, pc, valid, exc}; i_hold freezes it, else it takes i_load ? entry : bubble
module ifid_reg import cpu_pkg::*; (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_hold,
  input  logic        i_load,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  input  logic        i_exc,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic        o_valid,
  output logic        o_exc
);
  always_ff @(posedge clk)
    if (reset) begin
      o_instr <= NOP_INSTR;
      o_pc <= '0;
      o_valid <= 1'b0;
      o_exc <= 1'b0;
    end else if (!i_hold) begin
      o_instr <= i_load ? i_instr : NOP_INSTR;
      o_pc <= i_pc;
      o_valid <= i_load;
      o_exc <= i_load && i_exc;
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage; holds pc_f, fetches via im_req/gnt/rvalid, absorbs stalls in a hold buffer, drives IF/ID
module fetch_unit import cpu_pkg::*; #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned IM_DEPTH = IM_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] next_pc,
  output logic [31:0] pc_f,
  output logic [31:0] pc_add4_f,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_gnt,
  input  logic        im_rvalid,
  input  logic [31:0] im_rdata,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic        valid_d,
  output logic        exc_adel_d
);
  fetch_state_e r_state, w_state_nxt;
  logic [31:0] r_pc, r_hold_instr, w_instr;
  logic r_hold_exc, w_legal, w_done, w_adv, w_exc, w_im_req;
  assign w_legal = addr_legal(r_pc, RESET_PC, IM_DEPTH);
  assign w_done = (r_state == FS_REQ && !w_legal) || (r_state == FS_WAIT && im_rvalid);
  assign w_adv = !stall && (w_done || r_state == FS_HELD);
  assign w_exc = r_state == FS_REQ;
  assign w_instr = r_state == FS_WAIT ? im_rdata : NOP_INSTR;
  always_ff @(posedge clk)
    if (reset) r_state <= FS_REQ;
    else r_state <= w_state_nxt;
  always_comb
    w_state_nxt = w_adv ? FS_REQ :
                  w_done ? FS_HELD :
                  (r_state == FS_REQ && w_legal && im_gnt) ? FS_WAIT : r_state;
  always_comb
    w_im_req = r_state == FS_REQ && w_legal;
  always_ff @(posedge clk)
    if (reset) r_pc <= RESET_PC;
    else if (w_adv) r_pc <= next_pc;
  always_ff @(posedge clk)
    if (reset) begin
      r_hold_instr <= NOP_INSTR;
      r_hold_exc <= 1'b0;
    end else if (w_done && stall) begin
      r_hold_instr <= w_instr;
      r_hold_exc <= w_exc;
    end
  ifid_reg u_ifid (
    .clk     (clk),
    .reset   (reset),
    .i_hold  (stall),
    .i_load  (w_adv),
    .i_instr (r_state == FS_HELD ? r_hold_instr : w_instr),
    .i_pc    (r_pc),
    .i_exc   (r_state == FS_HELD ? r_hold_exc : w_exc),
    .o_instr (instr_d),
    .o_pc    (pc_d),
    .o_valid (valid_d),
    .o_exc   (exc_adel_d)
  );
  assign pc_f = r_pc;
  assign pc_add4_f = r_pc + 32'd4;
  assign im_req = w_im_req;
  assign im_addr = r_pc;
endmodule
